// File: rtl/g15_pkg.sv
// g15_pkg: definitions shared by the turn-on sequencer and the drum-timing
// monitors.
//   ts_state_t        - turn-on sequencer states, encoded as shown on the
//                       maintenance panel STATE lamps.
//   ts_outs_t         - bundle of the registered turn-on control outputs.
//   DRUM_BITS_PER_REV - clocks (bit times) per drum revolution.
//   DEF_*             - default parameter values for the sequencer.
//   rev_load()        - revolution-counter preload for an N-revolution phase.
//   ts_decode()       - Moore decode from a state to its control outputs.
package g15_pkg;

    localparam int DRUM_BITS_PER_REV  = 3132;

    localparam int DEF_WARMUP_REVS    = 4;
    localparam int DEF_CLEAR_REVS     = 2;
    localparam int DEF_NT_REVS        = 1;
    localparam int DEF_OP_REVS        = 1;
    localparam int DEF_ORIGIN_TIMEOUT = 3200;

    localparam int REV_W = 4;   // revolution counter width
    localparam int WD_W  = 12;  // origin watchdog counter width

    typedef enum logic [2:0] {
        TS_OFF     = 3'd0,
        TS_WARMUP  = 3'd1,
        TS_CLEAR   = 3'd2,
        TS_NT_LOAD = 3'd3,
        TS_OP      = 3'd4,
        TS_NO_OP   = 3'd5,
        TS_RUN     = 3'd6,
        TS_FAULT   = 3'd7
    } ts_state_t;

    typedef struct packed {
        logic clear;
        logic no_clear;
        logic nt;
        logic op;
        logic no_op;
        logic run;
        logic fault;
    } ts_outs_t;

    // A phase of N revolutions preloads N-1; N = 0 behaves as N = 1.
    // N above 16 does not fit the 4-bit counter and is truncated.
    function automatic logic [REV_W-1:0] rev_load(input int revs);
        if (revs <= 1) begin
            return '0;
        end
        return REV_W'(revs - 1);
    endfunction

    function automatic ts_outs_t ts_decode(input ts_state_t s);
        ts_outs_t o;
        o = '0;
        case (s)
            TS_NT_LOAD: begin
                o.no_clear = 1'b1;
                o.nt       = 1'b1;
            end
            TS_OP: begin
                o.no_clear = 1'b1;
                o.op       = 1'b1;
            end
            TS_NO_OP: begin
                o.no_clear = 1'b1;
                o.no_op    = 1'b1;
            end
            TS_RUN: begin
                o.no_clear = 1'b1;
                o.no_op    = 1'b1;
                o.run      = 1'b1;
            end
            TS_FAULT: begin
                o.clear = 1'b1;
                o.fault = 1'b1;
            end
            default: begin
                // OFF, WARMUP, CLEAR: hold CQ clear, number track cleared.
                o.clear = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/origin_watchdog.sv
// origin_watchdog: counts clocks since the last drum origin pulse.
//   clk     in  system clock (one drum bit time)
//   rst_n   in  asynchronous active-low reset
//   hold    in  force the count to 0 (monitor disarmed)
//   origin  in  one-clock origin strobe; clears the count
//   timeout out high in the clock whose edge brings the count to TIMEOUT,
//               and while the count sits saturated at TIMEOUT
// The count clears on origin, otherwise increments and saturates at TIMEOUT.
// timeout looks one edge ahead so a consumer registering it reacts on the
// same edge the count reaches TIMEOUT; it is forced low by hold or origin.
module origin_watchdog
    import g15_pkg::*;
#(
    parameter int TIMEOUT = DEF_ORIGIN_TIMEOUT,
    parameter int W       = WD_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic origin,
    output logic timeout
);

    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (hold || origin) begin
            count_q <= '0;
        end else if (count_q != LIMIT) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign timeout = !hold && !origin && (count_q >= (LIMIT - 1'b1));

endmodule

// File: rtl/turn_on_sequencer.sv
// turn_on_sequencer: steps the machine from power-on through number-track
// clear, number-track load and operating-mode entry, ending in RUN.
//   CLOCK        in  system clock, one clock = one drum bit time
//   rst          in  asynchronous active-low reset
//   PWR_ON       in  power switch (level)
//   DC_READY     in  supplies stable (level); only examined in OFF
//   DRUM_ORIGIN  in  one-clock strobe at word 0 / T0, once per revolution.
//                    There is no handshake: each strobe is consumed in the
//                    clock it is high and never stalls.
//   PWR_CLEAR    out clear CQ
//   PWR_NO_CLEAR out 0 = clear the number track
//   PWR_NT       out copy M19 into the number track
//   PWR_OP       out reset CY and CG
//   PWR_NO_OP    out set CY
//   RUN          out sequence complete
//   FAULT        out origin timeout, sticky until PWR_ON drops
//   STATE        out current state (ts_state_t encoding) for the panel
// All outputs come straight from flops; none has a combinational path from
// an input. Priority within one clock: PWR_ON low, then timeout, then origin.
module turn_on_sequencer
    import g15_pkg::*;
#(
    parameter int WARMUP_REVS    = DEF_WARMUP_REVS,
    parameter int CLEAR_REVS     = DEF_CLEAR_REVS,
    parameter int NT_REVS        = DEF_NT_REVS,
    parameter int OP_REVS        = DEF_OP_REVS,
    parameter int ORIGIN_TIMEOUT = DEF_ORIGIN_TIMEOUT
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       PWR_ON,
    input  logic       DC_READY,
    input  logic       DRUM_ORIGIN,
    output logic       PWR_CLEAR,
    output logic       PWR_NO_CLEAR,
    output logic       PWR_NT,
    output logic       PWR_OP,
    output logic       PWR_NO_OP,
    output logic       RUN,
    output logic       FAULT,
    output logic [2:0] STATE
);

    ts_state_t        state_q, state_d;
    ts_state_t        adv_state;
    logic [REV_W-1:0] rev_q, rev_d, adv_load;
    logic             started_q, started_d;
    ts_outs_t         outs_q, outs_d;
    logic             wd_hold, wd_timeout;

    // The watchdog is disarmed while the machine is off or already faulted.
    assign wd_hold = (state_q == TS_OFF) || (state_q == TS_FAULT);

    origin_watchdog #(
        .TIMEOUT(ORIGIN_TIMEOUT),
        .W      (WD_W)
    ) u_origin_watchdog (
        .clk    (CLOCK),
        .rst_n  (rst),
        .hold   (wd_hold),
        .origin (DRUM_ORIGIN),
        .timeout(wd_timeout)
    );

    // Where each timed phase goes when its last revolution ends, and the
    // counter preload for that next phase. NO_OP is always one revolution.
    always_comb begin
        adv_state = state_q;
        adv_load  = '0;
        case (state_q)
            TS_WARMUP: begin
                adv_state = TS_CLEAR;
                adv_load  = rev_load(CLEAR_REVS);
            end
            TS_CLEAR: begin
                adv_state = TS_NT_LOAD;
                adv_load  = rev_load(NT_REVS);
            end
            TS_NT_LOAD: begin
                adv_state = TS_OP;
                adv_load  = rev_load(OP_REVS);
            end
            TS_OP: begin
                adv_state = TS_NO_OP;
                adv_load  = '0;
            end
            TS_NO_OP: begin
                adv_state = TS_RUN;
                adv_load  = '0;
            end
            default: begin
                adv_state = state_q;
                adv_load  = '0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rev_d     = rev_q;
        started_d = started_q;

        if (!PWR_ON) begin
            state_d   = TS_OFF;
            rev_d     = '0;
            started_d = 1'b0;
        end else if (wd_timeout) begin
            state_d   = TS_FAULT;
            rev_d     = '0;
            started_d = 1'b0;
        end else begin
            case (state_q)
                TS_OFF: begin
                    if (DC_READY) begin
                        state_d   = TS_WARMUP;
                        rev_d     = rev_load(WARMUP_REVS);
                        started_d = 1'b0;
                    end
                end
                TS_WARMUP, TS_CLEAR, TS_NT_LOAD, TS_OP, TS_NO_OP: begin
                    if (DRUM_ORIGIN) begin
                        if ((state_q == TS_WARMUP) && !started_q) begin
                            // WARMUP is entered off-origin; its first origin
                            // only marks the start of revolution 1.
                            started_d = 1'b1;
                        end else if (rev_q == '0) begin
                            state_d = adv_state;
                            rev_d   = adv_load;
                        end else begin
                            rev_d = rev_q - 1'b1;
                        end
                    end
                end
                default: begin
                    // RUN and FAULT hold until PWR_ON drops.
                end
            endcase
        end

        outs_d = ts_decode(state_d);
    end

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            state_q   <= TS_OFF;
            rev_q     <= '0;
            started_q <= 1'b0;
            outs_q    <= ts_decode(TS_OFF);
        end else begin
            state_q   <= state_d;
            rev_q     <= rev_d;
            started_q <= started_d;
            outs_q    <= outs_d;
        end
    end

    assign PWR_CLEAR    = outs_q.clear;
    assign PWR_NO_CLEAR = outs_q.no_clear;
    assign PWR_NT       = outs_q.nt;
    assign PWR_OP       = outs_q.op;
    assign PWR_NO_OP    = outs_q.no_op;
    assign RUN          = outs_q.run;
    assign FAULT        = outs_q.fault;
    assign STATE        = state_q;

endmodule

// File: tb/tb_turn_on_sequencer.sv
// Directed bench for turn_on_sequencer. u_a uses the default parameters,
// u_b overrides CLEAR_REVS to 0; both share the same stimulus.
module tb_turn_on_sequencer;

    logic CLOCK       = 1'b0;
    logic rst         = 1'b0;
    logic PWR_ON      = 1'b0;
    logic DC_READY    = 1'b0;
    logic DRUM_ORIGIN = 1'b0;

    logic       a_clear, a_no_clear, a_nt, a_op, a_no_op, a_run, a_fault;
    logic [2:0] a_state;
    logic       b_clear, b_no_clear, b_nt, b_op, b_no_op, b_run, b_fault;
    logic [2:0] b_state;

    localparam int REV = 3132;

    // Expected {CLEAR, NO_CLEAR, NT, OP, NO_OP, RUN, FAULT}, written by hand.
    localparam logic [6:0] O_OFF  = 7'b1000000;  // OFF, WARMUP, CLEAR
    localparam logic [6:0] O_NT   = 7'b0110000;
    localparam logic [6:0] O_OP   = 7'b0101000;
    localparam logic [6:0] O_NOOP = 7'b0100100;
    localparam logic [6:0] O_RUN  = 7'b0100110;
    localparam logic [6:0] O_FLT  = 7'b1000001;

    // State after each of the ten origins of the nominal run.
    int         exp_a[10] = '{1, 1, 1, 1, 2, 2, 3, 4, 5, 6};
    int         exp_b[10] = '{1, 1, 1, 1, 2, 3, 4, 5, 6, 6};
    logic [6:0] exp_o[10] = '{O_OFF, O_OFF, O_OFF, O_OFF, O_OFF,
                              O_OFF, O_NT, O_OP, O_NOOP, O_RUN};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int nt_cnt = 0;
    int clr_b_cnt = 0;
    int run_cyc = -1;
    int o1_cyc = 0;

    turn_on_sequencer u_a (
        .CLOCK(CLOCK), .rst(rst), .PWR_ON(PWR_ON), .DC_READY(DC_READY),
        .DRUM_ORIGIN(DRUM_ORIGIN),
        .PWR_CLEAR(a_clear), .PWR_NO_CLEAR(a_no_clear), .PWR_NT(a_nt),
        .PWR_OP(a_op), .PWR_NO_OP(a_no_op), .RUN(a_run), .FAULT(a_fault),
        .STATE(a_state)
    );

    turn_on_sequencer #(.CLEAR_REVS(0)) u_b (
        .CLOCK(CLOCK), .rst(rst), .PWR_ON(PWR_ON), .DC_READY(DC_READY),
        .DRUM_ORIGIN(DRUM_ORIGIN),
        .PWR_CLEAR(b_clear), .PWR_NO_CLEAR(b_no_clear), .PWR_NT(b_nt),
        .PWR_OP(b_op), .PWR_NO_OP(b_no_op), .RUN(b_run), .FAULT(b_fault),
        .STATE(b_state)
    );

    // Clock / reset block
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, a_clear, a_no_clear, a_nt, a_op, a_no_op, a_run, a_fault},
            {25'd0, exp});
    endtask

    // One clock; outputs are sampled 1 time unit after the active edge.
    task automatic clk1();
        @(posedge CLOCK);
        #1;
        cyc++;
        if (a_nt) nt_cnt++;
        if (b_state == 3'd2) clr_b_cnt++;
        if (a_run && run_cyc < 0) run_cyc = cyc;
    endtask

    task automatic origin_edge();
        DRUM_ORIGIN = 1'b1;
        clk1();
        DRUM_ORIGIN = 1'b0;
    endtask

    task automatic rev(input int gap);
        origin_edge();
        repeat (gap - 1) clk1();
    endtask

    initial begin
        // Reset state
        repeat (2) clk1();
        chk("rst_state", a_state, 0);
        chk_outs("rst_outs", O_OFF);
        chk("rst_fault", a_fault, 0);

        rst = 1'b1;
        clk1();
        chk("off_idle", a_state, 0);
        PWR_ON = 1'b1;
        clk1();
        chk("off_no_dc", a_state, 0);
        DC_READY = 1'b1;
        clk1();
        chk("to_warmup", a_state, 1);
        chk_outs("warmup_outs", O_OFF);
        repeat (5) clk1();

        // Nominal sequence, origin every 3132 clocks
        for (int r = 0; r < 10; r++) begin
            if (r == 9) chk("run_low_before_o10", a_run, 0);
            origin_edge();
            if (r == 0) o1_cyc = cyc;
            chk($sformatf("nom_a_state_o%0d", r + 1), a_state, exp_a[r]);
            chk($sformatf("nom_b_state_o%0d", r + 1), b_state, exp_b[r]);
            chk_outs($sformatf("nom_outs_o%0d", r + 1), exp_o[r]);
            if (r < 9) repeat (REV - 1) clk1();
        end
        chk("nt_high_len", nt_cnt, REV);
        chk("run_latency", run_cyc - o1_cyc + 1, 9 * REV + 1);
        chk("clear_revs0_len", clr_b_cnt, REV);

        origin_edge();
        chk("run_holds", a_state, 6);
        PWR_ON = 1'b0;
        clk1();
        chk("run_pwr_off", a_state, 0);
        chk_outs("run_pwr_off_outs", O_OFF);

        // Reset mid-CLEAR with no clock edge (short origin spacing)
        PWR_ON = 1'b1;
        clk1();
        chk("seq2_warmup", a_state, 1);
        repeat (5) rev(16);
        chk("seq2_in_clear", a_state, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_state", a_state, 0);
        chk_outs("async_rst_outs", O_OFF);
        #1;
        rst = 1'b1;
        clk1();
        chk("restart_warmup", a_state, 1);

        // Origins stop in NT_LOAD
        repeat (6) rev(16);
        origin_edge();
        chk("fault_pre_nt", a_state, 3);
        repeat (3199) clk1();
        chk("fault_not_yet", a_state, 3);
        clk1();
        chk("fault_state", a_state, 7);
        chk_outs("fault_outs", O_FLT);

        // FAULT recovery
        repeat (8) clk1();
        chk("fault_sticky", a_state, 7);
        origin_edge();
        chk("fault_ignores_origin", a_state, 7);
        PWR_ON = 1'b0;
        clk1();
        chk("fault_to_off", a_state, 0);
        chk("fault_cleared", a_fault, 0);
        PWR_ON = 1'b1;
        clk1();
        chk("recover_warmup", a_state, 1);
        chk("recover_fault_low", a_fault, 0);

        // PWR_ON dropped in OP in the same clock as an origin
        repeat (8) rev(16);
        chk("seq3_in_op", a_state, 4);
        chk_outs("seq3_op_outs", O_OP);
        PWR_ON = 1'b0;
        origin_edge();
        chk("drop_state", a_state, 0);
        chk("drop_op", a_op, 0);
        chk("drop_clear", a_clear, 1);

        // No origin at all after entering WARMUP
        PWR_ON = 1'b1;
        clk1();
        chk("noorg_warmup", a_state, 1);
        repeat (3199) clk1();
        chk("noorg_not_yet", a_state, 1);
        clk1();
        chk("noorg_fault", a_state, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
